// File: rtl/tt_harness_pkg.sv
// Shared definitions for the TinyTapeout iCEBreaker harness blocks.
//   uart_state_e        : UART transmitter states (IDLE, START, DATA, STOP)
//   CLKS_PER_BIT_115200 : CLK cycles per bit at 115200 baud from a 12 MHz clock
//   BYTE_W              : width of the DUT io_out bus and of one UART data byte
package tt_harness_pkg;

  localparam int BYTE_W              = 8;
  localparam int CLKS_PER_BIT_115200 = 104;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/io_out_uart_reporter_if.sv
// Bundle between the DUT-side harness and the io_out UART reporter.
//   dut_clk  : divided DUT clock, a register in the CLK domain
//   dut_out  : DUT io_out bus
//   tx       : UART TX line, idle high
//   busy     : queue non-empty or a frame in progress
//   overflow : sticky flag, a changed sample was dropped on a full queue
// Modports: master drives the DUT side, slave is the reporter.
interface io_out_uart_reporter_if;
  import tt_harness_pkg::*;

  logic              dut_clk;
  logic [BYTE_W-1:0] dut_out;
  logic              tx;
  logic              busy;
  logic              overflow;

  modport master (output dut_clk, dut_out, input tx, busy, overflow);
  modport slave  (input dut_clk, dut_out, output tx, busy, overflow);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO: dout always shows the oldest
// entry while empty is low. Pushes when full and pops when empty are ignored.
// Reusable for the upstream input-injection path as well.
//   CLK, rst : clock, synchronous active-high reset
//   push/din : write strobe and data
//   pop/dout : read strobe and head-of-queue data
//   full, empty : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers define validity,
  // and leaving it out of reset lets it map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/io_out_uart_reporter.sv
// Watches the DUT io_out bus once per rising edge of the divided DUT clock,
// queues values that differ from the previous sample, and streams them out
// as 8N1 UART bytes (LSB first). Everything is in the CLK domain.
//   CLK, rst      : system clock, synchronous active-high reset
//   bus.dut_clk   : divided DUT clock (CLK-domain register)
//   bus.dut_out   : DUT io_out value
//   bus.tx        : registered UART TX, idle high
//   bus.busy      : queue non-empty or frame in progress
//   bus.overflow  : sticky, a changed sample was dropped; cleared by rst only
module io_out_uart_reporter
  import tt_harness_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,  // >= 2
  parameter int FIFO_DEPTH   = 4                     // power of two, >= 2
) (
  input logic                    CLK,
  input logic                    rst,
  io_out_uart_reporter_if.slave  bus
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // Sampling side
  logic              dut_clk_q;
  logic              rise;
  logic              sample;
  logic              have_last;
  logic [BYTE_W-1:0] last_value;
  logic              overflow_q;

  // Queue
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_dout;
  logic              pop;

  // Transmitter
  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;

  // The edge detector keeps tracking dut_clk during reset, so a dut_clk that
  // is already high when rst drops is not mistaken for a new rising edge.
  always_ff @(posedge CLK) begin
    dut_clk_q <= bus.dut_clk;
  end

  assign rise   = bus.dut_clk & ~dut_clk_q;
  assign sample = rise & (~have_last | (bus.dut_out != last_value));

  // last_value follows every changed sample, including one dropped on a full
  // queue, so the next differing value is still recognised as a change.
  always_ff @(posedge CLK) begin
    if (rst) begin
      have_last  <= 1'b0;
      last_value <= '0;
      overflow_q <= 1'b0;
    end else if (sample) begin
      have_last  <= 1'b1;
      last_value <= bus.dut_out;
      if (fifo_full) overflow_q <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .rst   (rst),
    .push  (sample & ~fifo_full),
    .din   (bus.dut_out),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the line level for the *next* cycle, so the registered tx lines
  // up with the state it belongs to (pop at k+1, start bit from k+2).
  // NOTE: every output gets a default first so no path leaves one unassigned
  // (which would infer a latch); blocking assignments here let shift_d be
  // read back within the same evaluation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          cnt_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
          tx_d  = 1'b0;
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[BYTE_W-1:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_d[0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          tx_d  = shift_q[0];
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = ~fifo_empty | (state_q != IDLE);
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_io_out_uart_reporter.sv
// Self-checking bench for io_out_uart_reporter (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A scoreboard queue holds the bytes expected on tx; a monitor decodes each
// frame cycle by cycle and compares every bit slot against the expected byte.
module tb_io_out_uart_reporter;
  import tt_harness_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic rst = 1'b1;

  io_out_uart_reporter_if bus_if();

  io_out_uart_reporter #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  sb[$];
  int          gaps[$];
  int          frames_seen = 0;
  int          last_start  = 0;
  int          last_end    = -100;
  bit          in_frame    = 1'b0;

  typedef struct {
    logic [7:0] value;
    logic       exp_frame;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame monitor: starts on the first low sample after a high one and
  // samples every cycle of the 10 slots; aborts if rst is seen mid-frame.
  initial begin : monitor
    logic       tx_prev;
    logic [7:0] exp;
    logic [3:0] samples;
    logic       lvl;
    bit         have_exp;
    bit         aborted;
    tx_prev = 1'b1;
    forever begin
      @(negedge CLK);
      if (!rst && tx_prev === 1'b1 && bus_if.tx === 1'b0) begin
        in_frame   = 1'b1;
        last_start = cyc;
        frames_seen++;
        gaps.push_back(cyc - last_end - 1);
        have_exp = (sb.size() != 0);
        exp      = 8'h00;
        if (have_exp) exp = sb.pop_front();
        else check("unexpected_frame", 32'd1, 32'd0);
        aborted = 1'b0;
        for (int s = 0; s < 10; s++) begin
          samples = '0;
          for (int c = 0; c < CPB; c++) begin
            if (!(s == 0 && c == 0)) @(negedge CLK);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            samples[c] = bus_if.tx;
          end
          if (aborted) break;
          lvl = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : exp[s-1];
          if (have_exp)
            check($sformatf("frame_%02h_slot%0d", exp, s), samples, {4{lvl}});
        end
        last_end = cyc;
        in_frame = 1'b0;
      end
      tx_prev = bus_if.tx;
    end
  end

  // One dut_clk period: high for period/2 cycles, returns on a posedge.
  task automatic rise_pulse(input logic [7:0] v, input int period, output int c0);
    @(posedge CLK); #1;
    bus_if.dut_out = v;
    bus_if.dut_clk = 1'b1;
    c0 = cyc;
    repeat (period / 2) @(posedge CLK);
    #1 bus_if.dut_clk = 1'b0;
    repeat (period - period / 2 - 1) @(posedge CLK);
  endtask

  task automatic apply_vec(input int i);
    @(posedge CLK); #1;
    bus_if.dut_out = vecs[i].value;
    bus_if.dut_clk = 1'b1;
    if (vecs[i].exp_frame) sb.push_back(vecs[i].value);
    @(posedge CLK);
    @(negedge CLK);
    check($sformatf("vec%0d_overflow", i), bus_if.overflow, vecs[i].exp_ovf);
    repeat (3) @(posedge CLK);
    #1 bus_if.dut_clk = 1'b0;
    repeat (3) @(posedge CLK);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(bus_if.busy === 1'b0 && sb.size() == 0 && !in_frame) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    repeat (2) @(negedge CLK);
    check({"drain_timeout_", tag}, (n >= budget), 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c0;
    int f0;
    int lows;

    // test3: unchanged A5; test4: back-to-back; test5: overflow on the sixth
    vecs[0]  = '{8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{8'hA5, 1'b0, 1'b0};
    vecs[2]  = '{8'hA5, 1'b0, 1'b0};
    vecs[3]  = '{8'hA5, 1'b0, 1'b0};
    vecs[4]  = '{8'hA5, 1'b0, 1'b0};
    vecs[5]  = '{8'h01, 1'b1, 1'b0};
    vecs[6]  = '{8'h02, 1'b1, 1'b0};
    vecs[7]  = '{8'h03, 1'b1, 1'b0};
    vecs[8]  = '{8'h01, 1'b1, 1'b0};
    vecs[9]  = '{8'h02, 1'b1, 1'b0};
    vecs[10] = '{8'h03, 1'b1, 1'b0};
    vecs[11] = '{8'h04, 1'b1, 1'b0};
    vecs[12] = '{8'h05, 1'b1, 1'b0};
    vecs[13] = '{8'h06, 1'b0, 1'b1};

    bus_if.dut_clk = 1'b0;
    bus_if.dut_out = 8'h3C;
    rst            = 1'b1;

    // 1. Reset with dut_clk toggling
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1 bus_if.dut_clk = ~bus_if.dut_clk;
      @(negedge CLK);
      check("rst_tx", bus_if.tx, 1'b1);
      check("rst_busy", bus_if.busy, 1'b0);
      check("rst_overflow", bus_if.overflow, 1'b0);
    end
    @(posedge CLK); #1;
    rst            = 1'b0;
    bus_if.dut_clk = 1'b0;
    @(negedge CLK);
    check("release_tx", bus_if.tx, 1'b1);
    check("release_busy", bus_if.busy, 1'b0);
    check("release_overflow", bus_if.overflow, 1'b0);
    repeat (4) @(negedge CLK);

    // 2. Single value A5: start bit at k+2, busy clears after the stop bit
    sb.push_back(8'hA5);
    rise_pulse(8'hA5, 8, c0);
    while (cyc < c0 + 41) @(negedge CLK);
    check("t2_start_cycle", last_start, c0 + 2);
    check("t2_busy_in_stop", bus_if.busy, 1'b1);
    @(negedge CLK);
    check("t2_busy_after", bus_if.busy, 1'b0);
    check("t2_tx_after", bus_if.tx, 1'b1);
    wait_idle("t2", 300);

    // 3. Unchanged value: no frames
    f0 = frames_seen;
    for (int i = 0; i <= 4; i++) apply_vec(i);
    repeat (50) @(negedge CLK);
    check("t3_frames", frames_seen - f0, 0);
    check("t3_busy", bus_if.busy, 1'b0);
    check("t3_tx", bus_if.tx, 1'b1);

    // 4. Back-to-back frames separated by one idle cycle
    gaps.delete();
    f0 = frames_seen;
    for (int i = 5; i <= 7; i++) apply_vec(i);
    wait_idle("t4", 400);
    check("t4_frames", frames_seen - f0, 3);
    check("t4_gap_count", gaps.size(), 3);
    if (gaps.size() >= 3) begin
      check("t4_gap1", gaps[1], 1);
      check("t4_gap2", gaps[2], 1);
    end

    // 5. Overflow: sixth value dropped, flag sticky
    f0 = frames_seen;
    for (int i = 8; i <= 13; i++) apply_vec(i);
    wait_idle("t5", 600);
    check("t5_frames", frames_seen - f0, 5);
    check("t5_overflow", bus_if.overflow, 1'b1);
    repeat (20) @(negedge CLK);
    check("t5_overflow_sticky", bus_if.overflow, 1'b1);

    // 6. Reset during DATA bit 3 of 0x55 with 0x66, 0x77 queued
    sb.push_back(8'h55);
    sb.push_back(8'h66);
    sb.push_back(8'h77);
    rise_pulse(8'h55, 8, c0);
    rise_pulse(8'h66, 8, f0);
    @(posedge CLK); #1;
    bus_if.dut_out = 8'h77;
    bus_if.dut_clk = 1'b1;
    repeat (3) @(posedge CLK);
    #1 rst = 1'b1;
    @(negedge CLK);
    check("t6_cycle_at_rst", cyc, c0 + 19);
    check("t6_tx_bit3", bus_if.tx, 1'b0);
    @(negedge CLK);
    check("t6_tx_after_rst", bus_if.tx, 1'b1);
    check("t6_busy_after_rst", bus_if.busy, 1'b0);
    @(posedge CLK); #1;
    rst            = 1'b0;
    bus_if.dut_clk = 1'b0;
    bus_if.dut_out = 8'h55;
    sb.delete();
    f0   = frames_seen;
    lows = 0;
    repeat (60) begin
      @(negedge CLK);
      if (bus_if.tx !== 1'b1) lows++;
    end
    check("t6_quiet_lows", lows, 0);
    check("t6_quiet_frames", frames_seen - f0, 0);
    check("t6_overflow_cleared", bus_if.overflow, 1'b0);
    check("t6_busy_quiet", bus_if.busy, 1'b0);
    sb.push_back(8'h55);
    rise_pulse(8'h55, 8, c0);
    wait_idle("t6", 300);
    check("t6_resend_frames", frames_seen - f0, 1);

    // First sample after reset is sent even when it equals the reset last_value
    @(posedge CLK); #1 rst = 1'b1;
    repeat (2) @(posedge CLK);
    #1 rst = 1'b0;
    f0 = frames_seen;
    sb.push_back(8'h00);
    rise_pulse(8'h00, 8, c0);
    wait_idle("first_zero", 300);
    check("first_zero_frames", frames_seen - f0, 1);
    f0 = frames_seen;
    rise_pulse(8'h00, 8, c0);
    repeat (50) @(negedge CLK);
    check("repeat_zero_frames", frames_seen - f0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
